pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed-field enable/clear stage registers between IF/ID/EX/MEM/WB. It carries a single packed payload of configurable width and supports full-throughput streaming, back-pressure without combinational ready paths, and a synchronous flush. Empty slots present a configurable bubble value, so downstream decode sees a NOP. A saturating stall counter supports hazard profiling.

## Interface
- DW, 32: payload width in bits (pack pc8/instr/AO/RD* fields upstream)
- NOP_VAL, {DW{1'b0}}: value driven on out_data when the stage is empty
- CNT_W, 16: stall counter width
- clk  in  1  clock; all state changes on posedge clk
- reset  in  1  synchronous, active-low reset; sampled on posedge clk
- clr  in  1  synchronous flush; drops all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; registered, not a combinational function of out_ready
- in_data  in  DW  upstream payload
- out_valid  out  1  stage holds a payload for downstream
- out_ready  in  1  downstream accepts
- out_data  out  DW  head payload, or NOP_VAL when out_valid=0
- occupancy  out  2  entries held, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload transfers only on a fire. in_data is ignored when in_fire=0.
- Storage:
  - main register (head) and skid register, each with its own valid bit.
  - out_data and out_valid come directly from main.
- States follow occupancy: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: in_ready=1. in_fire -> ONE, and main <= in_data.
  - ONE: in_ready=1.
    - in_fire & out_fire -> ONE, main <= in_data.
    - in_fire & !out_fire -> FULL, skid <= in_data.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> hold.
  - FULL: in_ready=0.
    - out_fire -> ONE, main <= skid.
    - Otherwise hold.
- Order is strictly FIFO. No payload is duplicated or lost except through clr or reset.
- in_ready is registered: it is 0 exactly when occupancy==2 after the edge.
- clr=1 (with reset=1):
  - Next state EMPTY; both valids cleared; out_data becomes NOP_VAL.
  - An in_fire in the same cycle is dropped.
  - out_fire in the same cycle still counts as taken by downstream.
  - stall_cnt is unaffected.
- reset=0:
  - Next state EMPTY; in_ready=1; out_valid=0; out_data=NOP_VAL; occupancy=0; stall_cnt=0.
  - Overrides clr and all handshake inputs.
- stall_cnt:
  - Increments by 1 on each posedge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Data registers need not be cleared on reset or clr. Only the valid bits and the NOP_VAL output mux are required.

## Timing
- Latency: in_fire at edge N gives out_valid=1 with that payload from edge N to N+1 (1 cycle) when the stage was EMPTY or ONE-with-out_fire.
- Throughput: 1 payload/cycle sustained while out_ready=1.
- Back-pressure: when out_ready drops, one further in_fire is absorbed (ONE -> FULL). in_ready falls at the following edge.
- Recovery: when out_ready returns, in_ready rises one cycle after the first out_fire from FULL.
- All outputs are registered or a mux of registers. There is no combinational path from in_* to out_*, nor from out_ready to in_ready.
- Reset values: in_ready=1, out_valid=0, out_data=NOP_VAL, occupancy=0, stall_cnt=0. These hold from the first posedge with reset=0.

## Test plan
- Streaming, DW=32, out_ready=1:
  - Stimulus: drive in_data=1,2,3,4 on consecutive cycles.
  - Required: out_data=1,2,3,4 on cycles 1-4; occupancy never exceeds 1; stall_cnt=0.
- Back-pressure:
  - Stimulus: out_ready=0 from cycle 2 while in_valid=1 with 0xA,0xB,0xC.
  - Required: occupancy reaches 2 and in_ready=0; 0xC is not accepted until out_ready=1. Output order is 0xA,0xB,0xC. stall_cnt equals the number of blocked cycles.
- Flush while FULL:
  - Stimulus: assert clr for one cycle with in_valid=1 and in_data=0x55.
  - Required: next cycle out_valid=0, out_data=NOP_VAL, occupancy=0, in_ready=1. 0x55 never appears.
- Reset mid-operation:
  - Stimulus: reset=0 for one cycle while FULL and stalled, with stall_cnt=7.
  - Required: all outputs at reset values, including stall_cnt=0. Behaviour is normal after reset=1.
- Saturation with CNT_W=4:
  - Stimulus: hold out_valid=1 and out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15.
- Bubble value:
  - Stimulus: NOP_VAL=32'hDEADBEEF, stage empty.
  - Required: out_data=32'hDEADBEEF while out_valid=0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready depends only on stored state, so back-pressure never forms a combinational ready chain.
module pipe_stage_buf #(
    parameter int unsigned     DW      = 32,
    parameter logic [DW-1:0]   NOP_VAL = '0,
    parameter int unsigned     CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding doubles as the occupancy count and carries both valid bits.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DW-1:0]     r_main;
    logic [DW-1:0]     r_skid;
    logic [DW-1:0]     w_main_nxt;
    logic [DW-1:0]     w_skid_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else if (clr) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers are qualified by r_state, so they need no reset.
    always_ff @(posedge clk) begin
        r_main <= w_main_nxt;
        r_skid <= w_skid_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = S_ONE;
                    w_main_nxt  = in_data;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt  = in_data;
                end else if (w_in_fire) begin
                    w_state_nxt = S_FULL;
                    w_skid_nxt  = in_data;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = S_ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (r_state != S_FULL);
        out_valid = (r_state != S_EMPTY);
        out_data  = (r_state != S_EMPTY) ? r_main : NOP_VAL;
        occupancy = r_state;
        stall_cnt = r_stall_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, saturation sequence, and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOP   = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             reset;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_buf #(.DW(DW), .NOP_VAL(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        clr;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic [1:0]  occ;
        logic        rdy;
        logic        ov;
        logic [31:0] od;
        logic [3:0]  st;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;

    task automatic v(input logic r, input logic c, input logic iv, input logic [31:0] id,
                     input logic ordy, input logic [1:0] occ, input logic rdy, input logic ov,
                     input logic [31:0] od, input logic [3:0] st);
        vec_t e;
        e.rst_n = r; e.clr = c; e.iv = iv; e.id = id; e.ordy = ordy;
        e.occ = occ; e.rdy = rdy; e.ov = ov; e.od = od; e.st = st;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
    endtask

    task automatic step(input logic r, input logic c, input logic iv, input logic [31:0] id, input logic ordy);
        reset = r; clr = c; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic [1:0] occ, input logic rdy, input logic ov,
                           input logic [31:0] od, input logic [3:0] st);
        chk("occupancy", idx, {30'd0, occupancy}, {30'd0, occ});
        chk("in_ready",  idx, {31'd0, in_ready},  {31'd0, rdy});
        chk("out_valid", idx, {31'd0, out_valid}, {31'd0, ov});
        chk("out_data",  idx, out_data, od);
        chk("stall_cnt", idx, {28'd0, stall_cnt}, {28'd0, st});
    endtask

    // Reference model: a FIFO of at most two payloads plus a saturating counter.
    logic [31:0] mq[$];
    int          mst;

    initial begin
        reset = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //  rst clr iv data   ordy  occ rdy ov data      st
        v(0, 0, 0, 32'h0,  0,   0, 1, 0, NOP,     0);   // reset / bubble value
        v(1, 0, 1, 32'h1,  1,   1, 1, 1, 32'h1,   0);   // streaming
        v(1, 0, 1, 32'h2,  1,   1, 1, 1, 32'h2,   0);
        v(1, 0, 1, 32'h3,  1,   1, 1, 1, 32'h3,   0);
        v(1, 0, 1, 32'h4,  1,   1, 1, 1, 32'h4,   0);
        v(1, 0, 0, 32'h0,  1,   0, 1, 0, NOP,     0);
        v(1, 0, 1, 32'hA,  1,   1, 1, 1, 32'hA,   0);   // back-pressure
        v(1, 0, 1, 32'hB,  0,   2, 0, 1, 32'hA,   1);
        v(1, 0, 1, 32'hC,  0,   2, 0, 1, 32'hA,   2);
        v(1, 0, 1, 32'hC,  0,   2, 0, 1, 32'hA,   3);
        v(1, 0, 1, 32'hC,  1,   1, 1, 1, 32'hB,   3);
        v(1, 0, 1, 32'hC,  1,   1, 1, 1, 32'hC,   3);
        v(1, 0, 0, 32'h0,  1,   0, 1, 0, NOP,     3);
        v(1, 0, 1, 32'hD,  0,   1, 1, 1, 32'hD,   3);   // flush while full
        v(1, 0, 1, 32'hE,  0,   2, 0, 1, 32'hD,   4);
        v(1, 1, 1, 32'h55, 0,   0, 1, 0, NOP,     5);
        v(1, 0, 1, 32'h11, 0,   1, 1, 1, 32'h11,  5);   // flush drops a real in_fire
        v(1, 1, 1, 32'h55, 0,   0, 1, 0, NOP,     6);
        v(1, 0, 0, 32'h0,  1,   0, 1, 0, NOP,     6);
        v(1, 0, 1, 32'h21, 0,   1, 1, 1, 32'h21,  6);   // reset while full and stalled
        v(1, 0, 1, 32'h22, 0,   2, 0, 1, 32'h21,  7);
        v(0, 0, 1, 32'h23, 0,   0, 1, 0, NOP,     0);
        v(1, 0, 1, 32'h33, 1,   1, 1, 1, 32'h33,  0);
        v(1, 0, 0, 32'h0,  1,   0, 1, 0, NOP,     0);
        v(1, 0, 1, 32'h44, 0,   1, 1, 1, 32'h44,  0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].clr, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk_all(i, tbl[i].occ, tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].st);
        end

        // Saturation: 20 stalled cycles with one entry held.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 32'h0, 0);
            chk("sat_cnt", 100 + i, {28'd0, stall_cnt}, (i + 1 > 15) ? 32'd15 : i + 1);
        end
        step(1, 0, 0, 32'h0, 1);
        chk_all(200, 0, 1, 0, NOP, 15);

        // Randomized run against the reference model, starting from reset.
        step(0, 0, 0, 32'h0, 0);
        mq.delete();
        mst = 0;
        for (int n = 0; n < 400; n++) begin
            logic r, c, iv, ordy, m_rdy, m_ov, ifire, ofire;
            logic [31:0] d;
            logic [31:0] exp_od;
            r    = ($urandom_range(0, 59) != 0);
            c    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 6 : 3));
            d    = $urandom;
            m_rdy = (mq.size() < 2);
            m_ov  = (mq.size() > 0);
            ifire = iv & m_rdy;
            ofire = m_ov & ordy;
            step(r, c, iv, d, ordy);
            if (!r) begin
                mq.delete();
                mst = 0;
            end else begin
                if (m_ov && !ordy && mst < 15) mst++;
                if (ofire) void'(mq.pop_front());
                if (c) mq.delete();
                else if (ifire) mq.push_back(d);
            end
            exp_od = (mq.size() > 0) ? mq[0] : NOP;
            chk_all(1000 + n, 2'(mq.size()), (mq.size() < 2), (mq.size() > 0), exp_od, 4'(mst));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
